// File: rtl/chan_scan_pkg.sv
// Shared constants and state type for the channel scanner.
package chan_scan_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    StIdle,
    StDwell
  } state_e;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority finder: first set bit of req at or after start, wrapping modulo 8.
module rr_pick8
  import chan_scan_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  // Walk from the farthest offset down so the nearest hit is the one that sticks.
  always_comb begin
    idx = start;
    any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[start + SEL_W'(i)]) begin
        idx = start + SEL_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_scan_ctrl.sv
// Round-robin scanner driving the 8:1 channel mux select/enable with a programmable dwell.
// Optional CHAN_SCAN_LOCK_EN adds a lock input that re-grants the current channel at done.
module chan_scan_ctrl
  import chan_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req,
  input  logic             hold,
`ifdef CHAN_SCAN_LOCK_EN
  input  logic             lock,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic [NCH-1:0]   grant,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] start, pick_idx;
  logic             pick_any;
  logic             relock;

  // While granting, ptr lags sel; the next search always begins just past the live grant.
  assign start = (state_q == StDwell) ? sel_q + SEL_W'(1) : ptr_q + SEL_W'(1);

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef CHAN_SCAN_LOCK_EN
  assign relock = lock & req[sel_q];
`else
  assign relock = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StDwell;
          sel_d   = pick_idx;
          cnt_d   = CntLoad;
        end
      end
      StDwell: begin
        if (!hold) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            done = 1'b1;
            if (relock) begin
              cnt_d = CntLoad;
            end else begin
              ptr_d = sel_q;
              if (pick_any) begin
                sel_d = pick_idx;
                cnt_d = CntLoad;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '1;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel = sel_q;
  assign en  = (state_q == StDwell);

  always_comb begin
    grant = '0;
    if (en) grant[sel_q] = 1'b1;
  end

endmodule
